// File: rtl/counter_2req_scheduler_pkg.sv
// Shared constants and helpers for the two-requester counter scheduler.
package counter_2req_scheduler_pkg;

  // FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Channel indices
  localparam int CH0 = 0;
  localparam int CH1 = 1;

  // Round-robin pick: a lone requester wins; on contention the channel
  // that did not win last time (ptr) takes the grant.
  function automatic logic pick_winner(input logic [1:0] req, input logic ptr);
    if (req[CH0] && req[CH1]) return ~ptr;
    else if (req[CH0])        return 1'b0;
    else                      return 1'b1;
  endfunction

  // One-hot vector for a channel index.
  function automatic logic [1:0] chan_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_2req_scheduler_core.sv
// Shared up-counter datapath: clear has priority over count enable.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Counter register: reset/clear to zero, otherwise step when enabled
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/counter_2req_scheduler.sv
// Round-robin scheduler sharing one up-counter between two requesters.
// A granted job clears the counter, steps it len times, then pulses done.
module counter_2req_scheduler
  import counter_2req_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       done
);

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic             ptr;     // last winner, which is also the channel being served
  logic             win;
  logic             start;
  logic             step;

  // Arbitration and counter control decoded from current state
  always_comb begin
    win   = pick_winner(req, ptr);
    start = (state == ST_IDLE) && (req != 2'b00);
    step  = (state == ST_RUN) && req[ptr] && (rem != '0);
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (step),
    .q   (q)
  );

  // Scheduler FSM with grant, done, busy and remaining-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= '0;
      ptr   <= 1'b1;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem   <= win ? len1 : len0;
            ptr   <= win;
            gnt   <= chan_onehot(win);
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!req[ptr]) begin
            // Requester withdrew: abandon the job silently, counter holds
            gnt   <= 2'b00;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rem == '0) begin
            gnt   <= 2'b00;
            done  <= chan_onehot(ptr);
            state <= ST_DONE;
          end else begin
            rem <= rem - WIDTH'(1);
          end
        end
        ST_DONE: begin
          done  <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          gnt   <= 2'b00;
          done  <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_2req_scheduler.sv
// Self-checking bench for counter_2req_scheduler: directed scenarios plus
// randomized traffic against a job-timeline reference model.
module tb_counter_2req_scheduler;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] q;
  logic [1:0]       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  counter_2req_scheduler #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .gnt  (gnt),
    .busy (busy),
    .q    (q),
    .done (done)
  );

  always #5 clk = ~clk;

  // Advance one active edge; outputs are then read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; len0 = 4'd3; len1 = 4'd3;
    tick();
    total_cnt++;
    if ({gnt, busy, q, done} !== 9'b0) $display("FAIL reset_outputs gnt=%b busy=%b q=%0d done=%b want all zero", gnt, busy, q, done);
    else pass_cnt++;
    rst = 1'b0; req = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; len0 = 4'd5; len1 = 4'd9;
    tick();
    total_cnt++;
    if (gnt !== 2'b01 || q !== 4'd0 || busy !== 1'b1) $display("FAIL single_grant gnt=%b q=%0d busy=%b want 01/0/1", gnt, q, busy);
    else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total_cnt++;
      if (q !== k[WIDTH-1:0] || gnt !== 2'b01 || done !== 2'b00) $display("FAIL single_count k=%0d q=%0d gnt=%b done=%b", k, q, gnt, done);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (done !== 2'b01 || gnt !== 2'b00 || q !== 4'd5) $display("FAIL single_done done=%b gnt=%b q=%0d want 01/00/5", done, gnt, q);
    else pass_cnt++;
    req = 2'b00;
    tick();
    total_cnt++;
    if (done !== 2'b00 || busy !== 1'b0 || q !== 4'd5) $display("FAIL single_idle done=%b busy=%b q=%0d want 00/0/5", done, busy, q);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic [1:0] g_seq [3];
    logic [1:0] d_seq [3];
    int         g_cyc [3];
    int         ng = 0;
    int         nd = 0;
    logic [1:0] prev_g = 2'b00;
    do_reset();
    req = 2'b11; len0 = 4'd3; len1 = 4'd2;
    for (int c = 0; c < 40 && (ng < 3 || nd < 3); c++) begin
      tick();
      if (gnt != 2'b00 && prev_g == 2'b00 && ng < 3) begin
        g_seq[ng] = gnt; g_cyc[ng] = c; ng++;
      end
      if (done != 2'b00 && nd < 3) begin
        d_seq[nd] = done; nd++;
      end
      prev_g = gnt;
    end
    req = 2'b00;
    total_cnt++;
    if (ng != 3 || nd != 3) $display("FAIL fair_timeout grants=%0d dones=%0d want 3/3", ng, nd);
    else begin
      pass_cnt++;
      total_cnt++;
      if ({g_seq[0], g_seq[1], g_seq[2]} !== 6'b01_10_01) $display("FAIL fair_gnt_seq got %b %b %b want 01 10 01", g_seq[0], g_seq[1], g_seq[2]);
      else pass_cnt++;
      total_cnt++;
      if ({d_seq[0], d_seq[1], d_seq[2]} !== 6'b01_10_01) $display("FAIL fair_done_seq got %b %b %b want 01 10 01", d_seq[0], d_seq[1], d_seq[2]);
      else pass_cnt++;
      total_cnt++;
      if (g_cyc[1] - g_cyc[0] != 6 || g_cyc[2] - g_cyc[1] != 5) $display("FAIL fair_period got %0d,%0d want 6,5", g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]);
      else pass_cnt++;
    end
    tick(); tick(); tick();
  endtask

  task automatic test_zero_len();
    do_reset();
    req = 2'b10; len0 = 4'd7; len1 = 4'd0;
    tick();
    total_cnt++;
    if (gnt !== 2'b10 || q !== 4'd0) $display("FAIL zero_grant gnt=%b q=%0d want 10/0", gnt, q);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 2'b10 || gnt !== 2'b00 || q !== 4'd0 || busy !== 1'b1) $display("FAIL zero_done done=%b gnt=%b q=%0d busy=%b", done, gnt, q, busy);
    else pass_cnt++;
    req = 2'b00;
    tick();
    total_cnt++;
    if (done !== 2'b00 || busy !== 1'b0) $display("FAIL zero_idle done=%b busy=%b want 00/0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic seen_done = 1'b0;
    do_reset();
    req = 2'b01; len0 = 4'd7;
    tick(); tick(); tick();
    total_cnt++;
    if (q !== 4'd2) $display("FAIL abort_setup q=%0d want 2", q);
    else pass_cnt++;
    req = 2'b00;
    tick();
    total_cnt++;
    if (gnt !== 2'b00 || busy !== 1'b0 || q !== 4'd2) $display("FAIL abort_stop gnt=%b busy=%b q=%0d want 00/0/2", gnt, busy, q);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done != 2'b00 || q != 4'd2) seen_done = 1'b1;
    end
    total_cnt++;
    if (seen_done) $display("FAIL abort_quiet done or q changed after abort (q=%0d done=%b)", q, done);
    else pass_cnt++;
  endtask

  task automatic test_full_range();
    logic ok = 1'b1;
    do_reset();
    req = 2'b01; len0 = 4'd15;
    tick();
    len0 = 4'd3;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (q != k[WIDTH-1:0] || gnt != 2'b01 || done != 2'b00) ok = 1'b0;
    end
    total_cnt++;
    if (!ok || q !== 4'd15) $display("FAIL full_count q=%0d gnt=%b want 15/01 without early stop", q, gnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 2'b01 || q !== 4'd15 || gnt !== 2'b00) $display("FAIL full_done done=%b q=%0d gnt=%b want 01/15/00", done, q, gnt);
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    req = 2'b01; len0 = 4'd7;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({gnt, busy, q, done} !== 9'b0) $display("FAIL midrst_outputs gnt=%b busy=%b q=%0d done=%b want zeros", gnt, busy, q, done);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (gnt !== 2'b01 || q !== 4'd0 || busy !== 1'b1) $display("FAIL midrst_regrant gnt=%b q=%0d busy=%b want 01/0/1", gnt, q, busy);
    else pass_cnt++;
    req = 2'b00;
    tick();
  endtask

  // Reference model: a job is described by channel, length and the cycle it
  // was granted; expected outputs follow from the offset into that job.
  task automatic test_random();
    int         m_active = 0;
    int         m_ch = 0;
    int         m_len = 0;
    int         m_start = 0;
    int         m_ptr = 1;
    int         m_q = 0;
    int         t;
    int         w;
    logic [1:0] e_gnt;
    logic [1:0] e_done;
    logic       e_busy;
    logic [1:0] r;
    logic [WIDTH-1:0] l0;
    logic [WIDTH-1:0] l1;
    logic       rs;
    do_reset();
    for (int cyc = 1; cyc <= 800; cyc++) begin
      r = req;
      for (int ch = 0; ch < 2; ch++) begin
        if (r[ch]) begin
          if ($urandom_range(0, 23) == 0) r[ch] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) r[ch] = 1'b1;
      end
      l0 = WIDTH'($urandom_range(0, 15));
      l1 = WIDTH'($urandom_range(0, 15));
      rs = ($urandom_range(0, 199) == 0);
      req = r; len0 = l0; len1 = l1; rst = rs;
      tick();
      e_gnt = 2'b00; e_done = 2'b00; e_busy = 1'b0;
      if (rs) begin
        m_active = 0; m_ptr = 1; m_q = 0;
      end else if (m_active == 0) begin
        if (r != 2'b00) begin
          w = (r == 2'b11) ? 1 - m_ptr : (r[0] ? 0 : 1);
          m_active = 1; m_ch = w; m_ptr = w; m_q = 0; m_start = cyc;
          m_len = (w == 1) ? int'(l1) : int'(l0);
          e_gnt = (w == 1) ? 2'b10 : 2'b01;
          e_busy = 1'b1;
        end
      end else begin
        t = cyc - m_start;
        if (t <= m_len + 1 && !r[m_ch]) begin
          m_active = 0;
        end else if (t <= m_len) begin
          m_q = t;
          e_gnt = (m_ch == 1) ? 2'b10 : 2'b01;
          e_busy = 1'b1;
        end else if (t == m_len + 1) begin
          e_done = (m_ch == 1) ? 2'b10 : 2'b01;
          e_busy = 1'b1;
        end else begin
          m_active = 0;
        end
      end
      total_cnt++;
      if (gnt !== e_gnt || done !== e_done || busy !== e_busy || q !== WIDTH'(m_q))
        $display("FAIL random_cyc%0d got gnt=%b done=%b busy=%b q=%0d want gnt=%b done=%b busy=%b q=%0d",
                 cyc, gnt, done, busy, q, e_gnt, e_done, e_busy, m_q);
      else pass_cnt++;
    end
    rst = 1'b0; req = 2'b00;
  endtask

  initial begin
    rst = 1'b0; req = 2'b00; len0 = '0; len1 = '0;
    test_reset();
    test_single();
    test_fairness();
    test_zero_len();
    test_abort();
    test_full_range();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
